frame_ram: RTL and testbench

FRAME_RAM -- requirements
Module: frame_ram

---
 rtl/frame_ram.sv | 136 +++++++++++++
 tb/tb_frame_ram.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/frame_ram.sv
// Single-clock frame buffer with a self-initialising fill sweep.
// One write port, one read port with optional output register and selectable read-during-write data.
module frame_ram #(
  parameter int                    ADDR_WIDTH = 14,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    OUT_REG    = 0,
  parameter int                    RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dvalid,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_fill_cnt;
  logic                  w_fill_last;

  logic                  w_busy;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic                  w_rd_accept;
  logic [DATA_WIDTH-1:0] w_rd_word;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;

  assign w_fill_last = (r_fill_cnt == {ADDR_WIDTH{1'b1}});

  // State register: reset lands in FILL so every reset triggers a full sweep.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FILL;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: if (w_fill_last) w_state_nxt = ST_IDLE;
      ST_IDLE: if (clear)       w_state_nxt = ST_FILL;
      default:                  w_state_nxt = ST_FILL;
    endcase
  end

  always_comb begin
    w_busy      = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_addr   = waddr;
    w_wr_data   = din;
    w_rd_accept = 1'b0;
    case (r_state)
      ST_FILL: begin
        w_busy    = 1'b1;
        w_wr_en   = 1'b1;
        w_wr_addr = r_fill_cnt;
        w_wr_data = FILL_VALUE;
      end
      ST_IDLE: begin
        w_wr_en     = we;
        w_rd_accept = re;
      end
      default: w_busy = 1'b1;
    endcase
  end

  // Counter only advances inside FILL and is parked at 0 otherwise, so it never wraps into a new sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_fill_cnt <= '0;
    else if (r_state == ST_FILL && !w_fill_last) r_fill_cnt <= r_fill_cnt + 1'b1;
    else                                      r_fill_cnt <= '0;
  end

  // NOTE: the memory array has no reset; the fill sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= w_wr_data;
  end

  // Same-address collision: the array read returns the pre-write word; RDW_MODE=1 forwards din instead.
  assign w_rd_word = (RDW_MODE != 0 && we && (waddr == raddr)) ? din : r_mem[raddr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_accept;
      if (w_rd_accept) r_rd_data <= w_rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  r_out_valid;
      logic [DATA_WIDTH-1:0] r_out_data;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_out_valid <= 1'b0;
          r_out_data  <= '0;
        end else begin
          r_out_valid <= r_rd_valid;
          if (r_rd_valid) r_out_data <= r_rd_data;
        end
      end

      assign dout   = r_out_data;
      assign dvalid = r_out_valid;
    end else begin : g_no_out_reg
      assign dout   = r_rd_data;
      assign dvalid = r_rd_valid;
    end
  endgenerate

  assign busy = w_busy;

endmodule

// File: tb/tb_frame_ram.sv
// Scoreboard bench for frame_ram: two instances (latency 1 / old-data / fill 00 and
// latency 2 / new-data / fill FF) share stimulus; an array model predicts every read.
module tb_frame_ram;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] din;
  logic          re;
  logic [AW-1:0] raddr;
  logic [DW-1:0] dout0, dout1;
  logic          dvalid0, dvalid1;
  logic          busy0, busy1;

  int            n_total = 0;
  int            n_pass  = 0;
  int            cyc     = 0;
  int            fill_left = 16;
  exp_t          q[2][$];
  logic [DW-1:0] m_mem[2][DEPTH];
  logic [DW-1:0] last_dout[2];
  int            oreg[2];
  int            rdw[2];
  logic [DW-1:0] fillv[2];

  always #5 clk = ~clk;

  frame_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0), .RDW_MODE(0), .FILL_VALUE(8'h00)) u_dut0 (
    .clk(clk), .rst(rst), .clear(clear), .we(we), .waddr(waddr), .din(din),
    .re(re), .raddr(raddr), .dout(dout0), .dvalid(dvalid0), .busy(busy0)
  );

  frame_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1), .RDW_MODE(1), .FILL_VALUE(8'hFF)) u_dut1 (
    .clk(clk), .rst(rst), .clear(clear), .we(we), .waddr(waddr), .din(din),
    .re(re), .raddr(raddr), .dout(dout1), .dvalid(dvalid1), .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic mon_port(input int id, input logic dv, input logic [DW-1:0] d, input logic b);
    logic exp_dv;
    exp_t e;
    exp_dv = (q[id].size() > 0) && (q[id][0].due == cyc);
    check($sformatf("busy%0d", id), {31'd0, b}, {31'd0, fill_left > 0});
    check($sformatf("dvalid%0d", id), {31'd0, dv}, {31'd0, exp_dv});
    if (exp_dv) begin
      e = q[id].pop_front();
      check($sformatf("dout%0d", id), {24'd0, d}, {24'd0, e.data});
      last_dout[id] = e.data;
    end else begin
      check($sformatf("dout_hold%0d", id), {24'd0, d}, {24'd0, last_dout[id]});
    end
  endtask

  always @(negedge clk) begin
    mon_port(0, dvalid0, dout0, busy0);
    mon_port(1, dvalid1, dout1, busy1);
  end

  // One clock of stimulus; the model applies the operation at the edge it is sampled on.
  task automatic drive(input logic c, input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] d,
                       input logic r, input logic [AW-1:0] ra);
    exp_t e;
    clear = c; we = w; waddr = wa; din = d; re = r; raddr = ra;
    @(posedge clk);
    cyc++;
    for (int id = 0; id < 2; id++) begin
      if (fill_left == 0) begin
        if (r) begin
          e.data = (rdw[id] != 0 && w && wa == ra) ? d : m_mem[id][ra];
          e.due  = cyc + oreg[id];
          q[id].push_back(e);
        end
        if (w) m_mem[id][wa] = d;
        if (c) for (int a = 0; a < DEPTH; a++) m_mem[id][a] = fillv[id];
      end
    end
    if (fill_left > 0) fill_left--;
    else if (c) fill_left = DEPTH;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; we = 1'b0; re = 1'b0;
    #1;
    check("rst_dvalid0", {31'd0, dvalid0}, 32'd0);
    check("rst_dvalid1", {31'd0, dvalid1}, 32'd0);
    check("rst_dout0", {24'd0, dout0}, 32'd0);
    check("rst_dout1", {24'd0, dout1}, 32'd0);
    check("rst_busy0", {31'd0, busy0}, 32'd1);
    check("rst_busy1", {31'd0, busy1}, 32'd1);
    for (int id = 0; id < 2; id++) begin
      q[id].delete();
      last_dout[id] = '0;
      for (int a = 0; a < DEPTH; a++) m_mem[id][a] = fillv[id];
    end
    fill_left = DEPTH;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1 rst = 1'b0;
  endtask

  initial begin
    oreg[0] = 0; rdw[0] = 0; fillv[0] = 8'h00;
    oreg[1] = 1; rdw[1] = 1; fillv[1] = 8'hFF;
    last_dout[0] = '0; last_dout[1] = '0;
    rst = 1'b1; clear = 1'b0; we = 1'b0; waddr = '0; din = '0; re = 1'b0; raddr = '0;
    @(posedge clk);
    cyc++;
    #1;
    do_reset();

    // Initial sweep, then read every address back-to-back.
    idle(DEPTH);
    for (int a = 0; a < DEPTH; a++) drive(1'b0, 1'b0, '0, '0, 1'b1, AW'(a));
    idle(3);

    // Write then read; same-cycle read-during-write on address 7.
    drive(1'b0, 1'b1, 4'd3, 8'hA5, 1'b0, '0);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 4'd3);
    drive(1'b0, 1'b1, 4'd7, 8'h11, 1'b0, '0);
    drive(1'b0, 1'b1, 4'd7, 8'h3C, 1'b1, 4'd7);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 4'd7);
    idle(3);

    // Four-deep read burst.
    for (int a = 0; a < 4; a++) drive(1'b0, 1'b1, AW'(a), 8'h10 + DW'(a), 1'b0, '0);
    for (int a = 0; a < 4; a++) drive(1'b0, 1'b0, '0, '0, 1'b1, AW'(a));
    idle(3);

    // Clear with a read issued on the entry cycle; writes, reads and clear during FILL are ignored.
    drive(1'b0, 1'b1, 4'd2, 8'h55, 1'b0, '0);
    drive(1'b1, 1'b0, '0, '0, 1'b1, 4'd2);
    drive(1'b0, 1'b1, 4'd2, 8'h77, 1'b1, 4'd2);
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
    idle(DEPTH - 2);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 4'd2);
    idle(3);

    // clear and we together: the write is swept over.
    drive(1'b1, 1'b1, 4'd9, 8'hEE, 1'b0, '0);
    idle(DEPTH);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 4'd9);
    idle(3);

    // Reset with a read in flight, then reset again at sweep cycle 9.
    drive(1'b0, 1'b1, 4'd4, 8'h99, 1'b0, '0);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 4'd4);
    do_reset();
    idle(9);
    do_reset();
    idle(DEPTH);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 4'd4);
    idle(3);

    // Randomised traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
            DW'($urandom), 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)));
    end
    idle(DEPTH + 4);

    check("q_empty0", q[0].size(), 32'd0);
    check("q_empty1", q[1].size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
